// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, LCD word field positions and status bits for the LCD driver.
package lcd_pkg;

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT} lcd_state_t;

    localparam int LCD_ON_BIT     = 31;
    localparam int LCD_RS_BIT     = 9;
    localparam int LCD_RW_BIT     = 8;
    localparam int LCD_DATA_LSB   = 0;
    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_OVERRUN_BIT = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that parks at zero and flags it.
module lcd_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: turns LCD register writes into HD44780 setup/enable/hold/exec timing
// with a power-up wait and a sticky overrun flag for dropped writes.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int T_PWRUP_CYC = 750_000,
    parameter int T_SETUP_CYC = 4,
    parameter int T_PULSE_CYC = 16,
    parameter int T_HOLD_CYC  = 4,
    parameter int T_EXEC_CYC  = 2_000,
    parameter int T_LONG_CYC  = 82_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lcd_wr,
    input  logic [31:0] i_lcd_word,
    output logic        o_busy,
    output logic        o_overrun,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    localparam int MAXP = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_PULSE_CYC, T_HOLD_CYC)),
                               max2(T_EXEC_CYC, T_LONG_CYC));
    localparam int W = $clog2(MAXP) + 1;

    lcd_state_t r_state, w_next;
    logic         w_load, w_accept, w_zero, w_long, w_unused;
    logic [W-1:0] w_value;
    logic         r_busy, r_overrun, r_on, r_en, r_rs, r_long;
    logic [7:0]   r_data;

    lcd_timer #(.W(W), .RST_VAL(W'(T_PWRUP_CYC - 1))) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_value (w_value),
        .o_zero  (w_zero)
    );

    // clear (0x01) and home (0x02/0x03) need the long execution wait
    assign w_long   = !i_lcd_word[LCD_RS_BIT] && (i_lcd_word[LCD_DATA_LSB+2 +: 6] == 6'd0)
                      && (i_lcd_word[LCD_DATA_LSB +: 8] != 8'd0);
    assign w_unused = ^{i_lcd_word[30:10], i_lcd_word[LCD_RW_BIT]};

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_value  = '0;
        w_accept = 1'b0;
        case (r_state)
            PWRUP: if (w_zero) w_next = IDLE;
            IDLE: if (i_lcd_wr) begin
                w_accept = 1'b1;
                w_next   = SETUP;
                w_load   = 1'b1;
                w_value  = W'(T_SETUP_CYC - 1);
            end
            SETUP: if (w_zero) begin
                w_next  = PULSE;
                w_load  = 1'b1;
                w_value = W'(T_PULSE_CYC - 1);
            end
            PULSE: if (w_zero) begin
                w_next  = HOLD;
                w_load  = 1'b1;
                w_value = W'(T_HOLD_CYC - 1);
            end
            HOLD: if (w_zero) begin
                w_next  = WAIT;
                w_load  = 1'b1;
                w_value = r_long ? W'(T_LONG_CYC - 1) : W'(T_EXEC_CYC - 1);
            end
            WAIT: if (w_zero) w_next = IDLE;
            default: w_next = PWRUP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= PWRUP;
            r_busy    <= 1'b1;
            r_overrun <= 1'b0;
            r_en      <= 1'b0;
            r_on      <= 1'b0;
            r_rs      <= 1'b0;
            r_data    <= 8'd0;
            r_long    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_en    <= (w_next == PULSE);
            if (i_lcd_wr && r_state != IDLE)
                r_overrun <= 1'b1;
            if (w_accept) begin
                r_on   <= i_lcd_word[LCD_ON_BIT];
                r_rs   <= i_lcd_word[LCD_RS_BIT];
                r_data <= i_lcd_word[LCD_DATA_LSB +: 8];
                r_long <= w_long;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;
    assign o_status   = (32'(r_overrun) << ST_OVERRUN_BIT) | (32'(r_busy) << ST_BUSY_BIT);
    assign o_lcd_on   = r_on;
    assign o_lcd_en   = r_en;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = r_data;

endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: directed scoreboard bench for lcd_driver with short timing parameters.
module tb_lcd_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] word = 32'd0;
    logic        busy, overrun, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [31:0] status;
    logic [7:0]  lcd_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          busy_n;
        int          en_n;
        int          en_first;
        int          pulses;
        logic        on;
        logic        rs;
        logic [7:0]  data;
        logic        ovr;
        logic [31:0] st_last;
    } exp_t;

    exp_t sb[$];
    int m_busy, m_en, m_first, m_pulses;
    logic [31:0] m_st;

    lcd_driver #(
        .T_PWRUP_CYC(10), .T_SETUP_CYC(2), .T_PULSE_CYC(3),
        .T_HOLD_CYC(2), .T_EXEC_CYC(5), .T_LONG_CYC(20)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_lcd_wr   (wr),
        .i_lcd_word (word),
        .o_busy     (busy),
        .o_overrun  (overrun),
        .o_status   (status),
        .o_lcd_on   (lcd_on),
        .o_lcd_en   (lcd_en),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int e, input int f, input int p, input logic on,
                        input logic rs, input logic [7:0] d, input logic ovr, input logic [31:0] st);
        exp_t x;
        x.busy_n = b; x.en_n = e; x.en_first = f; x.pulses = p;
        x.on = on; x.rs = rs; x.data = d; x.ovr = ovr; x.st_last = st;
        sb.push_back(x);
    endtask

    // Samples from the current point (k=0) until busy drops, optionally
    // injecting a strobe so that it is sampled at the edge after sample k=strobe_at.
    task automatic measure(input int strobe_at, input logic [31:0] sw);
        int k;
        logic prev;
        k = 0; prev = 1'b0;
        m_busy = 0; m_en = 0; m_first = -1; m_pulses = 0; m_st = 32'd0;
        while (k < 200 && busy) begin
            m_busy++;
            m_st = status;
            if (lcd_en) begin
                m_en++;
                if (m_first < 0) m_first = k;
                if (!prev) m_pulses++;
            end
            prev = lcd_en;
            wr = (k == strobe_at);
            if (k == strobe_at) word = sw;
            step();
            k++;
        end
        wr = 1'b0;
        chk("busy_bound", 32'(k < 200), 32'd1);
    endtask

    task automatic verify(input string tag);
        exp_t x;
        x = sb.pop_front();
        chk({tag, ".busy_len"}, 32'(m_busy), 32'(x.busy_n));
        chk({tag, ".en_len"}, 32'(m_en), 32'(x.en_n));
        chk({tag, ".en_first"}, 32'(m_first), 32'(x.en_first));
        chk({tag, ".pulses"}, 32'(m_pulses), 32'(x.pulses));
        chk({tag, ".status"}, m_st, x.st_last);
        chk({tag, ".on"}, 32'(lcd_on), 32'(x.on));
        chk({tag, ".rs"}, 32'(lcd_rs), 32'(x.rs));
        chk({tag, ".data"}, 32'(lcd_data), 32'(x.data));
        chk({tag, ".overrun"}, 32'(overrun), 32'(x.ovr));
        chk({tag, ".rw"}, 32'(lcd_rw), 32'd0);
    endtask

    task automatic xfer(input string tag, input logic [31:0] w, input int sa, input logic [31:0] sw);
        wr = 1'b1;
        word = w;
        step();
        wr = 1'b0;
        measure(sa, sw);
        verify(tag);
    endtask

    initial begin
        step(); step(); step();
        chk("rst.busy", 32'(busy), 32'd1);
        chk("rst.overrun", 32'(overrun), 32'd0);
        chk("rst.en", 32'(lcd_en), 32'd0);
        chk("rst.rs", 32'(lcd_rs), 32'd0);
        chk("rst.on", 32'(lcd_on), 32'd0);
        chk("rst.data", 32'(lcd_data), 32'd0);
        chk("rst.status", status, 32'd1);

        rst = 1'b1;
        push(10, 0, -1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd3);
        measure(2, 32'h8000_02ff);
        verify("pwrup_strobe");
        chk("pwrup.status_idle", status, 32'd2);

        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        push(10, 0, -1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd1);
        measure(-1, 32'd0);
        verify("pwrup_clean");
        step();

        push(12, 3, 2, 1, 1'b1, 1'b1, 8'h41, 1'b0, 32'd1);
        xfer("data41", 32'h8000_0241, -1, 32'd0);
        step(); step();
        push(27, 3, 2, 1, 1'b0, 1'b0, 8'h01, 1'b0, 32'd1);
        xfer("clear", 32'h0000_0001, -1, 32'd0);
        push(12, 3, 2, 1, 1'b0, 1'b0, 8'h80, 1'b0, 32'd1);
        xfer("cmd80", 32'h0000_0080, -1, 32'd0);
        push(27, 3, 2, 1, 1'b1, 1'b0, 8'h03, 1'b0, 32'd1);
        xfer("home3", 32'h8000_0003, -1, 32'd0);
        push(12, 3, 2, 1, 1'b0, 1'b0, 8'h04, 1'b0, 32'd1);
        xfer("cmd04", 32'h0000_0004, -1, 32'd0);
        push(12, 3, 2, 1, 1'b0, 1'b1, 8'h01, 1'b0, 32'd1);
        xfer("rs_data01", 32'h0000_0201, -1, 32'd0);

        push(12, 3, 2, 1, 1'b0, 1'b0, 8'h41, 1'b1, 32'd3);
        xfer("ovr_pulse", 32'h0000_0041, 2, 32'h0000_0042);
        chk("ovr.status_idle", status, 32'd2);

        wr = 1'b1;
        word = 32'h8000_0355;
        step();
        wr = 1'b0;
        step(); step(); step();
        chk("midrst.en_before", 32'(lcd_en), 32'd1);
        rst = 1'b0;
        step();
        chk("midrst.en", 32'(lcd_en), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd1);
        chk("midrst.overrun", 32'(overrun), 32'd0);
        chk("midrst.data", 32'(lcd_data), 32'd0);
        chk("midrst.on", 32'(lcd_on), 32'd0);
        chk("midrst.rs", 32'(lcd_rs), 32'd0);
        rst = 1'b1;
        push(10, 0, -1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd1);
        measure(-1, 32'd0);
        verify("midrst_pwrup");

        push(12, 3, 2, 1, 1'b0, 1'b0, 8'h41, 1'b1, 32'd1);
        xfer("last_wait", 32'h0000_0041, 11, 32'h0000_0099);
        push(12, 3, 2, 1, 1'b0, 1'b1, 8'h43, 1'b1, 32'd3);
        xfer("first_idle", 32'h0000_0243, -1, 32'd0);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
